instr_feeder: RTL and testbench

Autonomous program sequencer for the 10-bit bus processor: holds a small loadable program memory, drives the processor's external data input with the next program word, and generates the processor's active-low step clock. It replaces the switch-plus-KEY0 manual operator. It watches the controller's EXT (external-bus read) and DONE (Clr) outputs to decide when a word has been consumed and when an instruction has completed. It runs on the 50 MHz board clock, and its STEPb output feeds the processor's step-clock debouncer.

---
 rtl/instr_feeder_pkg.sv | 16 +
 rtl/feeder_prog_mem.sv | 27 ++
 rtl/instr_feeder.sv | 154 +++++++++++++++
 tb/tb_instr_feeder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
// Defines the processor word width, FSM state encoding and counter ceiling.
// No logic; imported by instr_feeder and feeder_prog_mem.
package instr_feeder_pkg;

  localparam int WORD_W  = 10;
  localparam int CNT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_prog_mem.sv
// Program memory: DEPTH x WORD_W, synchronous write, asynchronous read.
// Latency: write visible the cycle after the strobe; read is combinational.
// Backpressure: none; the caller gates the write strobe.
module feeder_prog_mem
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so a program survives RSTb.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_feeder.sv
// Autonomous program sequencer: presents program words and issues STEPb pulses.
// Latency: first STEPb fall 2 cycles after RUN is seen in IDLE; step = PULSE_LEN+GAP_LEN.
// Backpressure: none; a started LOW+HIGH pair always completes. Option: SINGLE_STEP_EN.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              CLK50M,
  input  logic              RSTb,
`ifdef SINGLE_STEP_EN
  input  logic              STEP_REQb,
`endif
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [WORD_W-1:0] LD_DATA,
  input  logic [ADDR_W:0]   PROG_LEN,
  input  logic              RUN,
  input  logic              EXT,
  input  logic              DONE,
  output logic              STEPb,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic [ADDR_W:0]   PTR,
  output logic [7:0]        INSTR_CNT,
  output logic              BUSY,
  output logic              HALT,
  output logic              ERR
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  phase;
  logic              ext_s, done_s;
  logic [ADDR_W:0]   ptr_post, ptr_nxt;
  logic [WORD_W-1:0] mem_rd, word_nxt;
  logic              last_low, last_high, underrun, start, halt_clr;
  logic              step_b_nxt;

  feeder_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (CLK50M),
    .we      (LD_EN && !BUSY),
    .wr_addr (LD_ADDR),
    .wr_data (LD_DATA),
    .rd_addr (ptr_nxt[ADDR_W-1:0]),
    .rd_data (mem_rd)
  );

`ifdef SINGLE_STEP_EN
  logic [1:0] req_sync;
  logic       req_prev;

  // Two-flop synchronizer plus history bit for falling-edge detection of the key.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      req_sync <= 2'b11;
      req_prev <= 1'b1;
    end else begin
      req_sync <= {req_sync[0], STEP_REQb};
      req_prev <= req_sync[1];
    end
  end

  // A key edge only starts a step when RUN is low; edges outside IDLE are ignored.
  assign start = RUN || (req_prev && !req_sync[1]);
`else
  assign start = RUN;
`endif

  assign last_low  = (state == ST_LOW)  && (phase == CNT_W'(PULSE_LEN - 1));
  assign last_high = (state == ST_HIGH) && (phase == CNT_W'(GAP_LEN - 1));
  assign underrun  = ext_s && (PTR == PROG_LEN);
  assign ptr_post  = (ext_s && !underrun) ? PTR + (ADDR_W+1)'(1) : PTR;
  assign halt_clr  = (state == ST_HALT) && !RUN;

  // Pointer for the coming cycle; the memory is read there so DATA_OUT tracks it.
  always_comb begin
    ptr_nxt = PTR;
    if (last_high) ptr_nxt = ptr_post;
    if (halt_clr)  ptr_nxt = '0;
  end

  assign word_nxt = (ptr_nxt < PROG_LEN) ? mem_rd : '0;

  // FSM state register.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state decision; step outcome is resolved on the last HIGH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (PROG_LEN == '0) ? ST_HALT : ST_LOW;
      ST_LOW:  if (last_low) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (last_high) begin
          if (underrun)                            state_nxt = ST_HALT;
          else if (done_s && ptr_post == PROG_LEN) state_nxt = ST_HALT;
          else if (RUN)                            state_nxt = ST_LOW;
          else                                     state_nxt = ST_IDLE;
        end
      end
      ST_HALT: if (!RUN) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; STEPb is registered from the current state, giving one cycle of lag.
  always_comb begin
    BUSY       = (state == ST_LOW) || (state == ST_HIGH);
    HALT       = (state == ST_HALT);
    step_b_nxt = (state != ST_LOW);
  end

  // Phase counter, sampled flags, pointer, instruction count, error and output word.
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      phase     <= '0;
      ext_s     <= 1'b0;
      done_s    <= 1'b0;
      PTR       <= '0;
      INSTR_CNT <= '0;
      ERR       <= 1'b0;
      DATA_OUT  <= '0;
      STEPb     <= 1'b1;
    end else begin
      phase <= (BUSY && state_nxt == state) ? phase + CNT_W'(1) : '0;
      STEPb <= step_b_nxt;
      PTR   <= ptr_nxt;
      if (last_low) begin
        ext_s  <= EXT;
        done_s <= DONE;
      end
      if (last_high && done_s && INSTR_CNT != 8'(CNT_MAX))
        INSTR_CNT <= INSTR_CNT + 8'd1;
      if (last_high && underrun)
        ERR <= 1'b1;
      if (halt_clr) begin
        INSTR_CNT <= '0;
        ERR       <= 1'b0;
      end
      // Word is frozen for the whole pulse pair and swaps exactly at the step boundary.
      if (!BUSY || last_high)
        DATA_OUT <= word_nxt;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with a per-step processor model.
// Checks reset, run-to-halt, multi-word, underrun, pause/resume, async reset, load lockout.
// Optional single-step check when SINGLE_STEP_EN is defined.
module tb_instr_feeder;

  logic       CLK50M = 1'b0;
  logic       RSTb   = 1'b1;
  logic       LD_EN  = 1'b0;
  logic [3:0] LD_ADDR = '0;
  logic [9:0] LD_DATA = '0;
  logic [4:0] PROG_LEN = '0;
  logic       RUN  = 1'b0;
  logic       EXT  = 1'b0;
  logic       DONE = 1'b0;
  logic       STEPb;
  logic [9:0] DATA_OUT;
  logic [4:0] PTR;
  logic [7:0] INSTR_CNT;
  logic       BUSY, HALT, ERR;
`ifdef SINGLE_STEP_EN
  logic       STEP_REQb = 1'b1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Processor model state: mode selects the EXT/DONE pattern per step.
  int         mode = 0;
  int         pulse_cnt = 0;
  int         step_base = 0;
  int         mk;
  logic [9:0] cap_data [32];
  logic [4:0] cap_ptr  [32];

  instr_feeder #(.DEPTH(16), .PULSE_LEN(4), .GAP_LEN(4)) dut (
    .CLK50M    (CLK50M),
    .RSTb      (RSTb),
`ifdef SINGLE_STEP_EN
    .STEP_REQb (STEP_REQb),
`endif
    .LD_EN     (LD_EN),
    .LD_ADDR   (LD_ADDR),
    .LD_DATA   (LD_DATA),
    .PROG_LEN  (PROG_LEN),
    .RUN       (RUN),
    .EXT       (EXT),
    .DONE      (DONE),
    .STEPb     (STEPb),
    .DATA_OUT  (DATA_OUT),
    .PTR       (PTR),
    .INSTR_CNT (INSTR_CNT),
    .BUSY      (BUSY),
    .HALT      (HALT),
    .ERR       (ERR)
  );

  always #10 CLK50M = ~CLK50M;

  // Processor model: on each STEPb fall, record the presented word and set EXT/DONE for that step.
  always @(negedge STEPb) begin
    mk = pulse_cnt - step_base;
    if (mk >= 0 && mk < 32) begin
      cap_data[mk] = DATA_OUT;
      cap_ptr[mk]  = PTR;
    end
    case (mode)
      1: begin EXT = (mk % 4 == 0); DONE = (mk % 4 == 3); end
      2: begin EXT = (mk % 4 < 2);  DONE = (mk % 4 == 3); end
      3: begin EXT = 1'b1;          DONE = 1'b0;          end
      default: begin EXT = 1'b0;    DONE = 1'b0;          end
    endcase
    pulse_cnt = pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [9:0] d);
    @(negedge CLK50M);
    LD_EN = 1'b1; LD_ADDR = a; LD_DATA = d;
    @(negedge CLK50M);
    LD_EN = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pulse_cnt - step_base >= n) break;
      @(negedge CLK50M);
    end
    chk(tag, 32'(pulse_cnt - step_base >= n), 32'd1);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (HALT) break;
      @(negedge CLK50M);
    end
    chk(tag, 32'(HALT), 32'd1);
  endtask

  task automatic clear_run();
    @(negedge CLK50M);
    RUN = 1'b0;
    repeat (2) @(negedge CLK50M);
    step_base = pulse_cnt;
  endtask

  initial begin
    int busy_n, low_n;

    // Reset values while RSTb is held low.
    #3 RSTb = 1'b0;
    #20;
    chk("rst_stepb", 32'(STEPb), 32'd1);
    chk("rst_data",  32'(DATA_OUT), 32'd0);
    chk("rst_ptr",   32'(PTR), 32'd0);
    chk("rst_icnt",  32'(INSTR_CNT), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_halt",  32'(HALT), 32'd0);
    chk("rst_err",   32'(ERR), 32'd0);
    @(negedge CLK50M);
    RSTb = 1'b1;

    load(4'd0, 10'h045);
    load(4'd1, 10'h0A3);
    load(4'd2, 10'h1C0);

    // Empty program: straight to HALT, no pulse.
    step_base = pulse_cnt;
    PROG_LEN = 5'd0;
    @(negedge CLK50M) RUN = 1'b1;
    repeat (2) @(negedge CLK50M);
    chk("empty_halt", 32'(HALT), 32'd1);
    chk("empty_err",  32'(ERR), 32'd0);
    repeat (10) @(negedge CLK50M);
    chk("empty_pulses", 32'(pulse_cnt - step_base), 32'd0);
    clear_run();
    chk("empty_idle", 32'(HALT), 32'd0);

    // Three single-word instructions; a load attempt during HIGH must be ignored.
    PROG_LEN = 5'd3;
    mode = 1;
    @(negedge CLK50M) RUN = 1'b1;
    wait_pulses("p3_first", 1, 40);
    for (int i = 0; i < 20; i++) begin
      if (STEPb) break;
      @(negedge CLK50M);
    end
    LD_EN = 1'b1; LD_ADDR = 4'd2; LD_DATA = 10'h3FF;
    chk("p3_ld_busy", 32'(BUSY), 32'd1);
    @(negedge CLK50M);
    LD_EN = 1'b0;
    wait_halt("p3_halt_to", 200);
    chk("p3_pulses", 32'(pulse_cnt - step_base), 32'd12);
    chk("p3_word0",  32'(cap_data[0]), 32'h045);
    chk("p3_word1",  32'(cap_data[4]), 32'h0A3);
    chk("p3_word2",  32'(cap_data[8]), 32'h1C0);
    chk("p3_icnt",   32'(INSTR_CNT), 32'd3);
    chk("p3_ptr",    32'(PTR), 32'd3);
    chk("p3_err",    32'(ERR), 32'd0);
    clear_run();
    chk("clr_icnt", 32'(INSTR_CNT), 32'd0);
    chk("clr_ptr",  32'(PTR), 32'd0);

    // Two-word instruction.
    PROG_LEN = 5'd2;
    mode = 2;
    @(negedge CLK50M) RUN = 1'b1;
    wait_halt("tw_halt_to", 200);
    chk("tw_ptr1",   32'(cap_ptr[1]), 32'd1);
    chk("tw_data1",  32'(cap_data[1]), 32'h0A3);
    chk("tw_ptr2",   32'(cap_ptr[2]), 32'd2);
    chk("tw_data2",  32'(cap_data[2]), 32'h000);
    chk("tw_pulses", 32'(pulse_cnt - step_base), 32'd4);
    chk("tw_icnt",   32'(INSTR_CNT), 32'd1);
    chk("tw_err",    32'(ERR), 32'd0);
    clear_run();

    // Underrun: EXT on every step with a one-word program.
    PROG_LEN = 5'd1;
    mode = 3;
    @(negedge CLK50M) RUN = 1'b1;
    wait_halt("ur_halt_to", 200);
    chk("ur_pulses", 32'(pulse_cnt - step_base), 32'd2);
    chk("ur_err",    32'(ERR), 32'd1);
    chk("ur_ptr",    32'(PTR), 32'd1);
    clear_run();
    chk("ur_err_clr", 32'(ERR), 32'd0);

    // RUN dropped one cycle into LOW: full pair completes, then pause with PTR kept.
    PROG_LEN = 5'd3;
    mode = 1;
    busy_n = 0;
    low_n  = 0;
    @(negedge CLK50M) RUN = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK50M);
      if (BUSY) busy_n++;
      if (!STEPb) low_n++;
      if (busy_n == 1) RUN = 1'b0;
      if (busy_n > 0 && !BUSY) break;
    end
    chk("ps_busy_len", 32'(busy_n), 32'd8);
    chk("ps_low_len",  32'(low_n), 32'd4);
    chk("ps_ptr",      32'(PTR), 32'd1);
    chk("ps_halt",     32'(HALT), 32'd0);
    repeat (6) @(negedge CLK50M);
    chk("ps_pulses", 32'(pulse_cnt - step_base), 32'd1);
    chk("ps_idle",   32'(BUSY), 32'd0);
    RUN = 1'b1;
    wait_pulses("rs_pulse", 2, 40);
    chk("rs_data", 32'(cap_data[1]), 32'h0A3);
    chk("rs_ptr",  32'(cap_ptr[1]), 32'd1);

    // Asynchronous reset in the middle of LOW.
    chk("mr_in_low", 32'(STEPb), 32'd0);
    RSTb = 1'b0;
    #1;
    chk("mr_stepb", 32'(STEPb), 32'd1);
    chk("mr_busy",  32'(BUSY), 32'd0);
    chk("mr_ptr",   32'(PTR), 32'd0);
    chk("mr_data",  32'(DATA_OUT), 32'd0);
    chk("mr_icnt",  32'(INSTR_CNT), 32'd0);
    chk("mr_halt",  32'(HALT), 32'd0);
    chk("mr_err",   32'(ERR), 32'd0);
    RUN = 1'b0;
    @(negedge CLK50M) RSTb = 1'b1;
    repeat (2) @(negedge CLK50M);
    chk("mr_mem_kept", 32'(DATA_OUT), 32'h045);

`ifdef SINGLE_STEP_EN
    // One key press in IDLE issues exactly one pulse pair.
    step_base = pulse_cnt;
    mode = 0;
    STEP_REQb = 1'b0;
    repeat (30) @(negedge CLK50M);
    STEP_REQb = 1'b1;
    repeat (10) @(negedge CLK50M);
    chk("ss_pulses", 32'(pulse_cnt - step_base), 32'd1);
    chk("ss_idle",   32'(BUSY), 32'd0);
    chk("ss_halt",   32'(HALT), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
